sub_seq_ctrl: RTL and testbench
===============================

# sub_seq_ctrl

Sequencing controller that performs WIDTH-bit subtraction by iterating one shared `substractor_4bit` nibble slice over successive nibbles, LSB first, with a registered borrow chain. It sits between the ALU operand bus and the result bus. It trades latency (one cycle per nibble) for reuse of a single 4-bit gate-level subtractor. Valid/ready handshakes are used on both sides.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4
- NIBBLES, WIDTH/4, derived localparam; number of RUN cycles
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  controller can accept request (high only in IDLE)
- i_op1  input  WIDTH  minuend
- i_op2  input  WIDTH  subtrahend
- i_borrow  input  1  borrow-in to nibble 0
- o_valid  output  1  result valid (high only in DONE)
- i_ready  input  1  consumer accepts result
- o_sub  output  WIDTH  difference
- o_borrow  output  1  final borrow-out
- o_zero  output  1  o_sub == 0
- o_busy  output  1  state is RUN

## Operation
- Result: o_sub = (i_op1 − i_op2 − i_borrow) mod 2^WIDTH; o_borrow = 1 iff i_op1 < i_op2 + i_borrow (unsigned).
- FSM states IDLE, RUN, DONE.
- IDLE: o_ready=1. On i_valid && o_ready:
  - capture i_op1, i_op2 and i_borrow into registers
  - clear nibble index k = 0 and the result register
  - go to RUN
- RUN: each cycle the slice computes nibble k of op1 − op2 − borrow_reg.
  - At the edge, the difference is written to result[4k+3:4k], borrow_reg takes the slice borrow-out, and k increments.
  - After nibble NIBBLES−1: o_borrow takes the final borrow, o_zero is computed from the full result, and the FSM goes to DONE.
- DONE: o_valid=1, and o_sub/o_borrow/o_zero are held stable. On i_valid... no: on o_valid && i_ready, go to IDLE. No request is accepted in the same cycle.
- Input pins are ignored outside the IDLE handshake. Operand changes during RUN/DONE have no effect.
- o_sub, o_borrow and o_zero are registered. They keep the last result through IDLE until the next DONE overwrites them.
- Reset, from any state (including mid-RUN or DONE with i_ready low), takes effect at the next edge:
  - FSM to IDLE
  - the in-flight operation is discarded, and o_valid is never asserted for it
- Reset values: o_ready=1, o_valid=0, o_busy=0, o_sub=0, o_borrow=0, o_zero=0, k=0, borrow_reg=0.

## Timing
- Accept edge E0. RUN occupies the NIBBLES cycles after E0.
- o_valid rises in the cycle following edge E0+NIBBLES, i.e. a latency of NIBBLES cycles (4 for WIDTH=16).
- If i_ready is high in the first DONE cycle, o_ready returns one cycle later.
- Minimum issue interval: NIBBLES+2 cycles.
- o_ready and o_valid are decoded from registered state only, with no combinational path from i_valid or i_ready.
- Slice path per cycle: one 4-bit ripple (4 full-subtractor stages) plus the mux selecting nibble k.

## Structure
- Package sub_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - NIBBLE_W = 4
  - function computing the index width, clog2(NIBBLES), minimum 1
- Sub-module: one instance of the existing `substractor_4bit`.
  - Inputs: nibble k of op1/op2, with borrow_reg as i_borrow.
  - Outputs: o_sub nibble and o_borrow feed the registers.
- Everything else is flat in sub_seq_ctrl: FSM, index counter, operand/result registers, zero detect.

## Test plan
- WIDTH=16, op1=0x1234, op2=0x0234, borrow=0 → o_sub=0x1000, o_borrow=0, o_zero=0; o_valid exactly 4 cycles after accept, o_busy high those 4 cycles.
- op1=0x0000, op2=0x0001, borrow=0 → o_sub=0xFFFF, o_borrow=1 (borrow propagates through all 4 nibbles).
- op1=0x5A5A, op2=0x5A59, borrow=1 → o_sub=0x0000, o_zero=1, o_borrow=0.
- Backpressure: hold i_ready=0 for 3 DONE cycles while driving i_valid=1 with new operands → o_valid, o_sub and o_borrow are stable and o_ready stays 0; once i_ready=1, IDLE is reached and the new request is accepted only after o_ready=1.
- Operands toggled to 0xFFFF/0x0000 during RUN of 0x8000−0x0001 → result 0x7FFF, o_borrow=0 (inputs ignored).
- i_rst pulsed in the 2nd RUN cycle → next cycle IDLE, o_ready=1, o_sub=0, o_valid never asserted; a following 0x0010−0x0001 returns 0x000F, o_borrow=0.

Source files
------------

// File: rtl/sub_seq_pkg.sv
// Shared types and helpers for the nibble-serial subtract controller.
// Imported by the controller and its 4-bit slice.
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int NIBBLE_W = 4;

    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/substractor_4bit.sv
// Gate-level 4-bit ripple subtractor: o_sub = i_a - i_b - i_borrow.
// o_borrow is the borrow-out of the top full-subtractor stage.
module substractor_4bit
    import sub_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_borrow,
    output logic [NIBBLE_W-1:0] o_sub,
    output logic                o_borrow
);

    logic [NIBBLE_W:0] chain;

    assign chain[0] = i_borrow;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fs
        logic axb;
        assign axb         = i_a[i] ^ i_b[i];
        assign o_sub[i]    = axb ^ chain[i];
        assign chain[i+1]  = (~i_a[i] & i_b[i]) | (~axb & chain[i]);
    end

    assign o_borrow = chain[NIBBLE_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// WIDTH-bit subtraction by iterating one 4-bit slice over the nibbles,
// LSB first, with a registered borrow chain and valid/ready handshakes.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_borrow,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sub,
    output logic             o_borrow,
    output logic             o_zero,
    output logic             o_busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    logic               bor_q, bor_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sub_q, sub_d;
    logic               obor_q, obor_d;
    logic               zero_q, zero_d;

    logic [NIBBLE_W-1:0] slice_diff;
    logic                slice_bout;
    logic [WIDTH-1:0]    merged;

    substractor_4bit u_slice (
        .i_a      (op1_q[k_q*NIBBLE_W +: NIBBLE_W]),
        .i_b      (op2_q[k_q*NIBBLE_W +: NIBBLE_W]),
        .i_borrow (bor_q),
        .o_sub    (slice_diff),
        .o_borrow (slice_bout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        bor_d   = bor_q;
        res_d   = res_q;
        sub_d   = sub_q;
        obor_d  = obor_q;
        zero_d  = zero_q;
        merged  = res_q;
        merged[k_q*NIBBLE_W +: NIBBLE_W] = slice_diff;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    op1_d   = i_op1;
                    op2_d   = i_op2;
                    bor_d   = i_borrow;
                    k_d     = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = merged;
                bor_d = slice_bout;
                k_d   = k_q + 1'b1;
                if (k_q == LAST) begin
                    // Publish the full result only once every nibble is in.
                    sub_d   = merged;
                    obor_d  = slice_bout;
                    zero_d  = (merged == '0);
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            bor_q   <= 1'b0;
            res_q   <= '0;
            sub_q   <= '0;
            obor_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            bor_q   <= bor_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            obor_q  <= obor_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q == RUN);
    assign o_sub    = sub_q;
    assign o_borrow = obor_q;
    assign o_zero   = zero_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl with hand-computed expected results.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sub_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             bin;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_op1    (op1),
        .i_op2    (op2),
        .i_borrow (bin),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_sub    (diff),
        .o_borrow (bout),
        .o_zero   (zero),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        in_valid = 1'b1;
        op1      = a;
        op2      = b;
        bin      = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result();
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        op1      = '0;
        op2      = '0;
        bin      = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_ready", {31'd0, out_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_sub",   {16'd0, diff},      32'd0);
        chk("rst_bout",  {31'd0, bout},      32'd0);
        chk("rst_zero",  {31'd0, zero},      32'd0);

        // 0x1234 - 0x0234: exact latency and busy window
        accept(16'h1234, 16'h0234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_busy",  {31'd0, busy},      32'd1);
            chk("t1_nvld",  {31'd0, out_valid}, 32'd0);
            chk("t1_nrdy",  {31'd0, out_ready}, 32'd0);
            step();
        end
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_idle",  {31'd0, busy},      32'd0);
        chk("t1_sub",   {16'd0, diff},      32'h1000);
        chk("t1_bout",  {31'd0, bout},      32'd0);
        chk("t1_zero",  {31'd0, zero},      32'd0);
        release_result();
        chk("t1_back",  {31'd0, out_ready}, 32'd1);
        chk("t1_vlow",  {31'd0, out_valid}, 32'd0);
        chk("t1_hold",  {16'd0, diff},      32'h1000);

        // 0x0000 - 0x0001: borrow ripples through every nibble
        accept(16'h0000, 16'h0001, 1'b0);
        wait_done("t2_done");
        chk("t2_sub",  {16'd0, diff}, 32'hFFFF);
        chk("t2_bout", {31'd0, bout}, 32'd1);
        chk("t2_zero", {31'd0, zero}, 32'd0);
        release_result();

        // 0x5A5A - 0x5A59 - 1 = 0
        accept(16'h5A5A, 16'h5A59, 1'b1);
        wait_done("t3_done");
        chk("t3_sub",  {16'd0, diff}, 32'h0000);
        chk("t3_zero", {31'd0, zero}, 32'd1);
        chk("t3_bout", {31'd0, bout}, 32'd0);
        release_result();

        // Backpressure with a pending new request
        accept(16'h0100, 16'h0001, 1'b0);
        wait_done("t4_done");
        in_valid = 1'b1;
        op1      = 16'hFFFF;
        op2      = 16'h0000;
        bin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_vhold", {31'd0, out_valid}, 32'd1);
            chk("t4_shold", {16'd0, diff},      32'h00FF);
            chk("t4_bhold", {31'd0, bout},      32'd0);
            chk("t4_nrdy",  {31'd0, out_ready}, 32'd0);
            step();
        end
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        chk("t4_idle",  {31'd0, out_ready}, 32'd1);
        chk("t4_nbusy", {31'd0, busy},      32'd0);
        step();
        in_valid = 1'b0;
        chk("t4_acc",   {31'd0, busy},      32'd1);
        wait_done("t4_done2");
        chk("t4_sub2",  {16'd0, diff}, 32'hFFFF);
        chk("t4_bout2", {31'd0, bout}, 32'd0);
        release_result();

        // Operands toggled during RUN are ignored
        accept(16'h8000, 16'h0001, 1'b0);
        op1 = 16'hFFFF;
        op2 = 16'h0000;
        bin = 1'b1;
        step();
        op1 = 16'h0000;
        op2 = 16'hFFFF;
        wait_done("t5_done");
        chk("t5_sub",  {16'd0, diff}, 32'h7FFF);
        chk("t5_bout", {31'd0, bout}, 32'd0);
        release_result();

        // Reset in the second RUN cycle discards the operation
        accept(16'h1234, 16'h0001, 1'b0);
        step();
        chk("t6_run", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ready", {31'd0, out_ready}, 32'd1);
        chk("t6_sub",   {16'd0, diff},      32'd0);
        chk("t6_busy",  {31'd0, busy},      32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t6_novld", {31'd0, out_valid}, 32'd0);
            step();
        end
        accept(16'h0010, 16'h0001, 1'b0);
        wait_done("t6_done");
        chk("t6_sub2",  {16'd0, diff}, 32'h000F);
        chk("t6_bout2", {31'd0, bout}, 32'd0);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
